// File: rtl/bike_bank_serializer.sv
// Snapshots one of NUM_OF_BANKS register banks and streams it out as 32-bit words,
// word 0 first, over a valid/ready handshake.
module bike_bank_serializer #(
  parameter int unsigned NUM_OF_BANKS = 4,
  parameter int unsigned BANK_SIZE    = 8,
  parameter int unsigned SEL_W        = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [SEL_W-1:0]          bank_sel,
  input  logic [BANK_SIZE*32-1:0]   bank_data [NUM_OF_BANKS],
  output logic [31:0]               dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      dout_last,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned BankW = BANK_SIZE * 32;
  localparam int unsigned CntW  = (BANK_SIZE > 1) ? $clog2(BANK_SIZE) : 1;

  localparam logic [CntW-1:0]  LastCnt  = CntW'(BANK_SIZE - 1);
  localparam logic [SEL_W:0]   NumBanks = (SEL_W + 1)'(NUM_OF_BANKS);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [BankW-1:0]  snap_q;
  logic [31:0]       dout_q;
  logic              valid_q;
  logic              last_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              in_range;
  logic [CntW-1:0]   cnt_inc;

  assign in_range = ({1'b0, bank_sel} < NumBanks);
  assign cnt_inc  = cnt_q + 1'b1;

  // The snapshot holds only the words not yet presented; it shifts down one word per beat
  // so the next word always sits in the low 32 bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      snap_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (in_range) begin
              snap_q  <= bank_data[bank_sel] >> 32;
              dout_q  <= bank_data[bank_sel][31:0];
              valid_q <= 1'b1;
              last_q  <= (LastCnt == '0);
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= StStream;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StStream: begin
          if (dout_ready) begin
            if (last_q) begin
              state_q <= StDone;
              cnt_q   <= '0;
              dout_q  <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q  <= cnt_inc;
              dout_q <= snap_q[31:0];
              snap_q <= snap_q >> 32;
              last_q <= (cnt_inc == LastCnt);
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign dout_last  = last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
